// File: rtl/sp_pkg.sv
// Shared types and constants for the 2-bit serial to 8-bit parallel deserializer.
package sp_pkg;

   localparam int unsigned PAIR_W  = 2;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned OUT_W   = BYTE_W + 1;
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned CNT_W   = 3;

   localparam logic [BYTE_W-1:0] COM            = 8'hBC;
   localparam logic [CNT_W-1:0]  COM_LOCK_COUNT = 3'd4;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ALIGNING = 2'd1,
      ACTIVE   = 2'd2
   } sp_state_t;

   // Parallel output word: valid flag above the data byte
   typedef struct packed {
      logic              valid;
      logic [BYTE_W-1:0] data;
   } sp_out_t;

endpackage

// File: rtl/serial_paralelo_2b_if.sv
// Serial lane in, assembled byte and lock status out.
interface serial_paralelo_2b_if;
   import sp_pkg::*;

   logic [PAIR_W-1:0] serial;
   logic [OUT_W-1:0]  paralelo;
   logic              paralelo_listo;
   logic              active;

   modport master (output serial, input paralelo, input paralelo_listo, input active);
   modport slave  (input serial, output paralelo, output paralelo_listo, output active);
endinterface

// File: rtl/sp_lock_fsm.sv
// Byte-alignment lock FSM: hunts for COM at any pair offset, then requires
// COM_LOCK_COUNT consecutive COMs on 4-pair boundaries before going ACTIVE.
module sp_lock_fsm
   import sp_pkg::*;
(
   input  logic              clk16f,
   input  logic              reset,
   input  logic [BYTE_W-1:0] byte_next,
   output logic              emit_c,
   output logic              active
);

   sp_state_t          state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
   logic               active_q, active_d;
   logic               is_com_c;
   logic               boundary_c;

   assign is_com_c   = (byte_next == COM);
   assign boundary_c = (phase_q == PHASE_W'(3));

   always_ff @(posedge clk16f) begin
      if (reset) begin
         state_q   <= UNLOCKED;
         phase_q   <= '0;
         com_cnt_q <= '0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         com_cnt_q <= com_cnt_d;
         active_q  <= active_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      com_cnt_d = com_cnt_q;
      unique case (state_q)
         UNLOCKED: begin
            if (is_com_c) begin
               state_d   = ALIGNING;
               com_cnt_d = CNT_W'(1);
               phase_d   = '0;
            end
         end
         ALIGNING: begin
            phase_d = phase_q + PHASE_W'(1);
            if (boundary_c) begin
               if (is_com_c) begin
                  // Saturating count; the lock-completing COM is consumed here
                  com_cnt_d = (com_cnt_q >= COM_LOCK_COUNT) ? COM_LOCK_COUNT
                                                            : com_cnt_q + CNT_W'(1);
                  if (com_cnt_d == COM_LOCK_COUNT) state_d = ACTIVE;
               end else begin
                  state_d   = UNLOCKED;
                  com_cnt_d = '0;
               end
            end
         end
         ACTIVE: begin
            phase_d = phase_q + PHASE_W'(1);
         end
         default: begin
            state_d   = UNLOCKED;
            phase_d   = '0;
            com_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      emit_c   = 1'b0;
      active_d = (state_d == ACTIVE);
      if (state_q == ACTIVE && boundary_c) emit_c = 1'b1;
   end

   assign active = active_q;

endmodule

// File: rtl/serial_paralelo_2b.sv
// 2-bit serial to parallel deserializer with COM-based byte lock.
// Build option SERIAL_PARALELO_STRIP_COM_EN: COM bytes in ACTIVE come out with valid=0.
module serial_paralelo_2b
   import sp_pkg::*;
(
   input  logic                 clk16f,
   input  logic                 reset,
   serial_paralelo_2b_if.slave  bus
);

   logic [BYTE_W-1:0] sr_q, sr_d;
   sp_out_t           paralelo_q, paralelo_d;
   logic              paralelo_listo_q, paralelo_listo_d;
   logic              emit_c;

   sp_lock_fsm u_lock_fsm (
      .clk16f    (clk16f),
      .reset     (reset),
      .byte_next (sr_d),
      .emit_c    (emit_c),
      .active    (bus.active)
   );

   always_ff @(posedge clk16f) begin
      if (reset) begin
         sr_q             <= '0;
         paralelo_q       <= '0;
         paralelo_listo_q <= 1'b0;
      end else begin
         sr_q             <= sr_d;
         paralelo_q       <= paralelo_d;
         paralelo_listo_q <= paralelo_listo_d;
      end
   end

   // The byte completed by the current pair is the shift register's next value
   always_comb begin
      sr_d             = {sr_q[BYTE_W-PAIR_W-1:0], bus.serial};
      paralelo_d       = paralelo_q;
      paralelo_listo_d = 1'b0;
      if (emit_c) begin
         paralelo_listo_d = 1'b1;
         paralelo_d.data  = sr_d;
`ifdef SERIAL_PARALELO_STRIP_COM_EN
         paralelo_d.valid = (sr_d != COM);
`else
         paralelo_d.valid = 1'b1;
`endif
      end
   end

   assign bus.paralelo       = paralelo_q;
   assign bus.paralelo_listo = paralelo_listo_q;

endmodule

// File: tb/tb_serial_paralelo_2b.sv
// Randomized scoreboard bench for serial_paralelo_2b against a behavioural lock model.
module tb_serial_paralelo_2b;

   localparam logic [7:0] BC = 8'hBC;
`ifdef SERIAL_PARALELO_STRIP_COM_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   logic clk16f = 1'b0;
   logic reset  = 1'b1;
   always #5 clk16f = ~clk16f;

   serial_paralelo_2b_if bus ();

   serial_paralelo_2b dut (
      .clk16f (clk16f),
      .reset  (reset),
      .bus    (bus)
   );

   // Reference model: byte window over the pair stream, lock tracked by cycle arithmetic
   logic [7:0] m_win    = 8'h00;
   int         m_mode   = 0;   // 0 hunting, 1 counting COMs, 2 locked
   int         m_coms   = 0;
   int         m_anchor = 0;
   int         m_n      = 0;
   logic [8:0] exp_par    = 9'h000;
   logic       exp_listo  = 1'b0;
   logic       exp_active = 1'b0;
   logic [8:0] sb_q[$];
   bit         mon_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic [1:0] pair, input logic rst);
      bus.serial = pair;
      reset      = rst;
      @(posedge clk16f);
      m_n++;
      exp_listo = 1'b0;
      if (rst) begin
         m_win  = 8'h00;
         m_mode = 0;
         m_coms = 0;
         exp_par = 9'h000;
      end else begin
         m_win = {m_win[5:0], pair};
         if (m_mode == 0) begin
            if (m_win == BC) begin
               m_mode   = 1;
               m_coms   = 1;
               m_anchor = m_n;
            end
         end else if (((m_n - m_anchor) % 4) == 0) begin
            if (m_mode == 1) begin
               if (m_win == BC) begin
                  m_coms++;
                  if (m_coms >= 4) m_mode = 2;
               end else begin
                  m_mode = 0;
                  m_coms = 0;
               end
            end else begin
               exp_par   = (STRIP && m_win == BC) ? {1'b0, m_win} : {1'b1, m_win};
               exp_listo = 1'b1;
               sb_q.push_back(exp_par);
            end
         end
      end
      exp_active = (m_mode == 2);
      mon_en     = 1'b1;
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 3; i >= 0; i--) step(b[i*2 +: 2], 1'b0);
   endtask

   task automatic send_coms(input int n);
      for (int i = 0; i < n; i++) send_byte(BC);
   endtask

   // Monitor: pops the scoreboard whenever the DUT flags a new byte
   always @(negedge clk16f) begin
      if (mon_en) begin
         if (bus.paralelo_listo === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_listo: got paralelo %h with no expected byte at %0t",
                        bus.paralelo, $time);
            end else begin
               chk("paralelo_byte", bus.paralelo, sb_q.pop_front());
            end
         end
         chk("paralelo_listo", {8'h00, bus.paralelo_listo}, {8'h00, exp_listo});
         chk("paralelo_hold", bus.paralelo, exp_par);
         chk("active", {8'h00, bus.active}, {8'h00, exp_active});
      end
   end

   initial begin
      bus.serial = 2'b00;
      // Idle line after reset never locks
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);
      repeat (20) step(2'b00, 1'b0);

      // Aligned lock then data
      send_coms(4);
      send_byte(8'h5A);
      step(2'b00, 1'b1);

      // Lock at odd pair offset
      step(2'b01, 1'b0);
      send_coms(4);
      send_byte(8'hFF);
      step(2'b00, 1'b1);

      // Broken lock attempt, then relock
      send_coms(3);
      send_byte(8'h12);
      send_coms(4);
      send_byte(8'h34);

      // COM while locked
      send_byte(BC);
      send_byte(8'h00);
      step(2'b00, 1'b1);

      // Reset during the third pair of a data byte
      send_coms(4);
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);
      step(2'b01, 1'b1);
      step(2'b01, 1'b0);
      repeat (8) step(2'b00, 1'b0);

      // Random pair noise while hunting
      step(2'b00, 1'b1);
      repeat (300) step(2'($urandom_range(0, 3)), 1'b0);

      // Random lock attempts and locked traffic, with occasional mid-stream reset
      repeat (8) begin
         step(2'b00, 1'b1);
         repeat ($urandom_range(0, 7)) step(2'($urandom_range(0, 3)), 1'b0);
         send_coms($urandom_range(2, 5));
         for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) send_byte(BC);
            else send_byte(8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) step(2'($urandom_range(0, 3)), 1'b0);
            step(2'($urandom_range(0, 3)), 1'b1);
            repeat (6) step(2'($urandom_range(0, 3)), 1'b0);
         end
      end

      repeat (3) step(2'b00, 1'b0);
      @(negedge clk16f);
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d bytes never presented, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_paralelo_2b.md
SERIAL_PARALELO_2B -- requirements
Module: serial_paralelo_2b

Interface
REQ-001 Ports SHALL be, clock and reset first:
REQ-002 clk16f  input  1  single clock; every register SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 serial  input  2  serial lane, one bit pair per clk16f cycle, MSB pair first (first pair = byte[7:6]).
REQ-005 paralelo  output  9  {valid, data[7:0]} of the last assembled byte, registered.
REQ-006 paralelo_listo  output  1  one-cycle pulse when paralelo is updated.
REQ-007 active  output  1  high while the lock FSM is in ACTIVE.

Function
REQ-008 Assembled byte SHALL be byte_next = {sr[5:0], serial}, where sr is the internal 8-bit shift register; sr SHALL shift in serial every cycle.
REQ-009 COM symbol SHALL be 8'hBC; lock threshold SHALL be 4 consecutive COMs.
REQ-010 FSM states SHALL be UNLOCKED, ALIGNING, ACTIVE.
REQ-011 UNLOCKED: byte_next compared every cycle (any phase); on match -> ALIGNING, com_cnt<=1, phase<=0.
REQ-012 ALIGNING/ACTIVE: 2-bit phase counter SHALL increment every cycle and wrap 3->0; byte boundary = cycle with phase==3.
REQ-013 ALIGNING, boundary, byte_next==COM: com_cnt+1; on reaching 4, -> ACTIVE at the same edge.
REQ-014 ALIGNING, boundary, byte_next!=COM: -> UNLOCKED, com_cnt<=0, no output update.
REQ-015 ACTIVE SHALL persist until reset; ACTIVE, boundary: paralelo<={1'b1, byte_next} for non-COM bytes, paralelo_listo<=1.
REQ-016 Latency: paralelo and paralelo_listo SHALL change at the edge sampling the last pair; visible 1 cycle after that pair was presented.
REQ-017 paralelo SHALL hold its value between boundaries; paralelo_listo SHALL be 0 on non-boundary cycles.
REQ-018 Outside ACTIVE: paralelo SHALL hold 9'h000, paralelo_listo 0; the lock-completing COM SHALL NOT produce an output.
REQ-019 com_cnt SHALL saturate at 4; no wrap-around.

Reset
REQ-020 reset SHALL have priority over all other events, including a boundary in the same cycle.
REQ-021 On reset: state UNLOCKED, sr=8'h00, phase=0, com_cnt=0, paralelo=9'h000, paralelo_listo=0, active=0.
REQ-022 Reset mid-byte or mid-lock SHALL discard partial data; relock requires 4 fresh COMs.

Configuration
REQ-023 Macro SERIAL_PARALELO_STRIP_COM_EN: defined -> COM bytes in ACTIVE SHALL output 9'h0BC (valid=0, idle) with paralelo_listo=1.
REQ-024 Undefined -> COM bytes in ACTIVE SHALL output 9'h1BC (valid=1) like data.

Structure
REQ-025 Package sp_pkg SHALL hold COM (8'hBC), COM_LOCK_COUNT (4), state typedef sp_state_t.
REQ-026 Sub-module sp_lock_fsm SHALL own state, phase, com_cnt; top owns sr and output registers.

Verification
REQ-027 reset 2 cycles, serial=2'b00 for 20 cycles -> paralelo=9'h000, active=0, paralelo_listo never 1.
REQ-028 4x BC (pairs 10,11,11,00), then 8'h5A -> active rises at 4th BC's last pair; paralelo=9'h15A, listo pulses once.
REQ-029 1 stray pair then 4x BC then 8'hFF -> lock at odd offset; paralelo=9'h1FF.
REQ-030 3x BC, 8'h12, then 4x BC, 8'h34 -> UNLOCKED after 8'h12 (no output), relock, paralelo=9'h134.
REQ-031 ACTIVE, send BC -> 9'h0BC with macro, 9'h1BC without.
REQ-032 ACTIVE, reset asserted at phase 2 of 8'hA5 -> outputs cleared next cycle, no 8'hA5 output, active=0.
